membus_arbiter: RTL and testbench

MEMBUS_ARBITER -- requirements
Module: membus_arbiter

---
 rtl/membus_arbiter.sv | 149 ++++++++++++++
 tb/tb_membus_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/membus_arbiter.sv
// membus_arbiter: two-client round-robin arbiter in front of a single-port
// synchronous memory. Grants are combinational, read data is broadcast to
// both clients, and a tag pipeline steers rvalid to the client that issued
// each read, READ_LATENCY cycles after it was accepted.
// Optional bus locking is compiled in when MEMBUS_ARB_LOCK_EN is defined.
module membus_arbiter #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  c0_req,
  input  logic [ADDR_WIDTH-1:0] c0_addr,
  input  logic [DATA_WIDTH-1:0] c0_wdata,
  input  logic                  c0_we,
`ifdef MEMBUS_ARB_LOCK_EN
  input  logic                  c0_lock,
`endif
  output logic                  c0_gnt,
  output logic [DATA_WIDTH-1:0] c0_rdata,
  output logic                  c0_rvalid,
  input  logic                  c1_req,
  input  logic [ADDR_WIDTH-1:0] c1_addr,
  input  logic [DATA_WIDTH-1:0] c1_wdata,
  input  logic                  c1_we,
`ifdef MEMBUS_ARB_LOCK_EN
  input  logic                  c1_lock,
`endif
  output logic                  c1_gnt,
  output logic [DATA_WIDTH-1:0] c1_rdata,
  output logic                  c1_rvalid,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_write_enable,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);

  logic                    gnt0;
  logic                    gnt1;
  logic                    any_gnt;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;
  logic                    sel_we;
  logic                    last_grant_reg;   // 1 = client 1 was granted most recently
  logic [ADDR_WIDTH-1:0]   addr_hold_reg;
  logic [DATA_WIDTH-1:0]   wdata_hold_reg;
  logic [READ_LATENCY-1:0] tag_valid_reg;
  logic [READ_LATENCY-1:0] tag_owner_reg;    // 1 = read belongs to client 1
  logic                    hold_lock;

`ifdef MEMBUS_ARB_LOCK_EN
  typedef enum logic {ARB = 1'b0, LOCKED = 1'b1} state_t;
  state_t state_reg;
  logic   lock_owner_reg;
  logic   sel_lock;

  // The owner keeps the bus only while it still asserts its lock; once it
  // drops lock, normal arbitration applies in that same cycle.
  assign hold_lock = (state_reg == LOCKED) && (lock_owner_reg ? c1_lock : c0_lock);
  assign sel_lock  = gnt1 ? c1_lock : c0_lock;
`else
  assign hold_lock = 1'b0;
`endif

  // Grant selection: lock owner first, then a lone requester, then round-robin tie-break
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst_n) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end else if (hold_lock) begin
`ifdef MEMBUS_ARB_LOCK_EN
      gnt0 = c0_req & ~lock_owner_reg;
      gnt1 = c1_req &  lock_owner_reg;
`endif
    end else if (c0_req && c1_req) begin
      gnt0 = last_grant_reg;
      gnt1 = ~last_grant_reg;
    end else begin
      gnt0 = c0_req;
      gnt1 = c1_req;
    end
  end

  assign any_gnt   = gnt0 | gnt1;
  assign sel_addr  = gnt1 ? c1_addr  : c0_addr;
  assign sel_wdata = gnt1 ? c1_wdata : c0_wdata;
  assign sel_we    = gnt1 ? c1_we    : c0_we;

  assign c0_gnt = gnt0;
  assign c1_gnt = gnt1;

  // Idle cycles keep the last driven address/data so the memory bus does not toggle
  assign mem_address      = any_gnt ? sel_addr  : addr_hold_reg;
  assign mem_write_data   = any_gnt ? sel_wdata : wdata_hold_reg;
  assign mem_write_enable = any_gnt & sel_we;

  // Read data is shared; only the rvalid strobes are steered by the tag pipeline
  assign c0_rdata  = mem_read_data;
  assign c1_rdata  = mem_read_data;
  assign c0_rvalid = tag_valid_reg[READ_LATENCY-1] & ~tag_owner_reg[READ_LATENCY-1];
  assign c1_rvalid = tag_valid_reg[READ_LATENCY-1] &  tag_owner_reg[READ_LATENCY-1];

  // Round-robin pointer and idle hold values advance only on an actual grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_reg <= 1'b1;
      addr_hold_reg  <= '0;
      wdata_hold_reg <= '0;
    end else if (any_gnt) begin
      last_grant_reg <= gnt1;
      addr_hold_reg  <= sel_addr;
      wdata_hold_reg <= sel_wdata;
    end
  end

  // Tag pipeline: a read pushes its owner, a write or idle cycle pushes an empty slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_valid_reg <= '0;
      tag_owner_reg <= '0;
    end else begin
      tag_valid_reg[0] <= any_gnt & ~sel_we;
      tag_owner_reg[0] <= gnt1;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_valid_reg[i] <= tag_valid_reg[i-1];
        tag_owner_reg[i] <= tag_owner_reg[i-1];
      end
    end
  end

`ifdef MEMBUS_ARB_LOCK_EN
  // Bus-lock state machine: enter LOCKED on a locked grant, return to ARB when the owner releases
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ARB;
      lock_owner_reg <= 1'b0;
    end else if (any_gnt && sel_lock) begin
      state_reg      <= LOCKED;
      lock_owner_reg <= gnt1;
    end else if (!hold_lock) begin
      state_reg      <= ARB;
    end
  end
`endif

endmodule

// File: tb/tb_membus_arbiter.sv
// Directed bench for membus_arbiter. Three instances share one stimulus set
// and differ only in READ_LATENCY (1, 2, 3); each has its own write-first
// memory model. Lock scenario is compiled when MEMBUS_ARB_LOCK_EN is defined.
module tb_membus_arbiter;

  logic        clk;
  logic        rst_n;
  logic        c0_req, c1_req;
  logic [15:0] c0_addr, c1_addr;
  logic [7:0]  c0_wdata, c1_wdata;
  logic        c0_we, c1_we;
`ifdef MEMBUS_ARB_LOCK_EN
  logic        c0_lock, c1_lock;
`endif

  logic [2:0]  c0_gnt_v, c1_gnt_v, c0_rv_v, c1_rv_v, mwe_v;
  logic [7:0]  c0_rd_v [3];
  logic [7:0]  c1_rd_v [3];
  logic [7:0]  mwd_v [3];
  logic [15:0] maddr_v [3];

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int LAT = gi + 1;
    logic [7:0] mem [0:65535];
    logic [7:0] rd_pipe [0:LAT-1];

    initial begin
      for (int a = 0; a < 65536; a++) mem[a] = 8'(a) ^ 8'h5A;
      mem[16'h0010] = 8'hA5;
      for (int i = 0; i < LAT; i++) rd_pipe[i] = 8'h00;
    end

    // Write-first synchronous memory with LAT cycles of read latency
    always @(posedge clk) begin
      if (mwe_v[gi]) mem[maddr_v[gi]] <= mwd_v[gi];
      rd_pipe[0] <= mwe_v[gi] ? mwd_v[gi] : mem[maddr_v[gi]];
      for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    membus_arbiter #(
      .ADDR_WIDTH(16), .DATA_WIDTH(8), .READ_LATENCY(LAT)
    ) dut (
      .clk(clk), .rst_n(rst_n),
      .c0_req(c0_req), .c0_addr(c0_addr), .c0_wdata(c0_wdata), .c0_we(c0_we),
`ifdef MEMBUS_ARB_LOCK_EN
      .c0_lock(c0_lock),
`endif
      .c0_gnt(c0_gnt_v[gi]), .c0_rdata(c0_rd_v[gi]), .c0_rvalid(c0_rv_v[gi]),
      .c1_req(c1_req), .c1_addr(c1_addr), .c1_wdata(c1_wdata), .c1_we(c1_we),
`ifdef MEMBUS_ARB_LOCK_EN
      .c1_lock(c1_lock),
`endif
      .c1_gnt(c1_gnt_v[gi]), .c1_rdata(c1_rd_v[gi]), .c1_rvalid(c1_rv_v[gi]),
      .mem_address(maddr_v[gi]), .mem_write_data(mwd_v[gi]),
      .mem_write_enable(mwe_v[gi]), .mem_read_data(rd_pipe[LAT-1])
    );
  end

  function automatic logic [7:0] exp_mem(input logic [15:0] a);
    return (a == 16'h0010) ? 8'hA5 : (a[7:0] ^ 8'h5A);
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    c0_req = 0; c1_req = 0; c0_we = 0; c1_we = 0;
    c0_addr = '0; c1_addr = '0; c0_wdata = '0; c1_wdata = '0;
`ifdef MEMBUS_ARB_LOCK_EN
    c0_lock = 0; c1_lock = 0;
`endif
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle_inputs();
    next_cycle();
    next_cycle();
    rst_n = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    next_cycle();
    c0_req = 1; c1_req = 1; c0_we = 1; c0_addr = 16'h1234; c0_wdata = 8'h77;
    #1;
    $display("reset: both requesting while rst_n=0");
    checks++; if (c0_gnt_v !== 3'b000 || c1_gnt_v !== 3'b000) begin errors++;
      $display("FAIL reset_gnt: c0_gnt=%b c1_gnt=%b required 000/000", c0_gnt_v, c1_gnt_v); end
    checks++; if (mwe_v !== 3'b000) begin errors++;
      $display("FAIL reset_we: got %b required 000", mwe_v); end
    checks++; if (maddr_v[0] !== 16'h0000 || mwd_v[0] !== 8'h00) begin errors++;
      $display("FAIL reset_bus: addr=%h wdata=%h required 0000/00", maddr_v[0], mwd_v[0]); end
    checks++; if (c0_rv_v !== 3'b000 || c1_rv_v !== 3'b000) begin errors++;
      $display("FAIL reset_rvalid: c0=%b c1=%b required 000/000", c0_rv_v, c1_rv_v); end
    next_cycle();
    idle_inputs();
    rst_n = 1;
  endtask

  task automatic test_single();
    c0_req = 1; c0_addr = 16'h0010; c0_we = 0;
    #1;
    $display("single: c0 read addr 0010");
    checks++; if (c0_gnt_v[0] !== 1'b1 || c1_gnt_v[0] !== 1'b0) begin errors++;
      $display("FAIL single_gnt: c0=%b c1=%b required 1/0", c0_gnt_v[0], c1_gnt_v[0]); end
    checks++; if (maddr_v[0] !== 16'h0010 || mwe_v[0] !== 1'b0) begin errors++;
      $display("FAIL single_bus: addr=%h we=%b required 0010/0", maddr_v[0], mwe_v[0]); end
    next_cycle();
    c0_req = 0;
    checks++; if (c0_rv_v[0] !== 1'b1 || c0_rd_v[0] !== 8'hA5) begin errors++;
      $display("FAIL single_rvalid: rvalid=%b rdata=%h required 1/a5", c0_rv_v[0], c0_rd_v[0]); end
    checks++; if (c1_rv_v[0] !== 1'b0 || c1_rd_v[0] !== 8'hA5) begin errors++;
      $display("FAIL single_other: c1_rvalid=%b c1_rdata=%h required 0/a5", c1_rv_v[0], c1_rd_v[0]); end
    next_cycle();
    checks++; if (c0_rv_v[0] !== 1'b0 || c1_rv_v[0] !== 1'b0) begin errors++;
      $display("FAIL single_pulse: c0=%b c1=%b required 0/0", c0_rv_v[0], c1_rv_v[0]); end
  endtask

  task automatic test_contention();
    int own;
    int prev;
    do_reset();
    c0_req = 1; c1_req = 1; c0_we = 0; c1_we = 0;
    c0_addr = 16'h0020; c1_addr = 16'h0021;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) begin c0_req = 0; c1_req = 0; end
      #1;
      if (k < 4) begin
        own = k % 2;
        $display("contention: cycle %0d expect grant c%0d", k, own);
        checks++; if (c0_gnt_v[0] !== (own == 0) || c1_gnt_v[0] !== (own == 1)) begin errors++;
          $display("FAIL contention_gnt k=%0d: c0=%b c1=%b required owner c%0d", k, c0_gnt_v[0], c1_gnt_v[0], own); end
        checks++; if (maddr_v[0] !== 16'h0020 + 16'(own)) begin errors++;
          $display("FAIL contention_addr k=%0d: got %h required %h", k, maddr_v[0], 16'h0020 + 16'(own)); end
      end
      if (k > 0) begin
        prev = (k - 1) % 2;
        checks++; if (c0_rv_v[0] !== (prev == 0) || c1_rv_v[0] !== (prev == 1)) begin errors++;
          $display("FAIL contention_rvalid k=%0d: c0=%b c1=%b required owner c%0d", k, c0_rv_v[0], c1_rv_v[0], prev); end
        checks++; if (c0_rd_v[0] !== exp_mem(16'h0020 + 16'(prev))) begin errors++;
          $display("FAIL contention_rdata k=%0d: got %h required %h", k, c0_rd_v[0], exp_mem(16'h0020 + 16'(prev))); end
      end
      next_cycle();
    end
  endtask

  task automatic test_write_read();
    c1_req = 1; c1_we = 1; c1_addr = 16'h0002; c1_wdata = 8'h3C;
    #1;
    $display("write_read: c1 write 3c to 0002");
    checks++; if (c1_gnt_v[0] !== 1'b1 || mwe_v[0] !== 1'b1) begin errors++;
      $display("FAIL wr_write: gnt=%b we=%b required 1/1", c1_gnt_v[0], mwe_v[0]); end
    checks++; if (maddr_v[0] !== 16'h0002 || mwd_v[0] !== 8'h3C) begin errors++;
      $display("FAIL wr_bus: addr=%h wdata=%h required 0002/3c", maddr_v[0], mwd_v[0]); end
    next_cycle();
    c1_we = 0;
    #1;
    $display("write_read: c1 read 0002");
    checks++; if (c1_gnt_v[0] !== 1'b1 || mwe_v[0] !== 1'b0) begin errors++;
      $display("FAIL wr_read: gnt=%b we=%b required 1/0", c1_gnt_v[0], mwe_v[0]); end
    checks++; if (c1_rv_v[0] !== 1'b0 || c0_rv_v[0] !== 1'b0) begin errors++;
      $display("FAIL wr_norvalid: c1=%b c0=%b required 0/0 after write", c1_rv_v[0], c0_rv_v[0]); end
    next_cycle();
    c1_req = 0;
    #1;
    checks++; if (c1_rv_v[0] !== 1'b1 || c1_rd_v[0] !== 8'h3C || c0_rv_v[0] !== 1'b0) begin errors++;
      $display("FAIL wr_rdata: rvalid=%b rdata=%h c0_rvalid=%b required 1/3c/0", c1_rv_v[0], c1_rd_v[0], c0_rv_v[0]); end
    checks++; if (mwe_v[0] !== 1'b0 || maddr_v[0] !== 16'h0002 || mwd_v[0] !== 8'h3C) begin errors++;
      $display("FAIL wr_idle_hold: we=%b addr=%h wdata=%h required 0/0002/3c", mwe_v[0], maddr_v[0], mwd_v[0]); end
    next_cycle();
  endtask

  task automatic test_latency();
    logic exp_v;
    do_reset();
    for (int k = 0; k < 7; k++) begin
      c0_req = (k < 3); c0_we = 0; c0_addr = 16'h0030 + 16'(k);
      #1;
      exp_v = (k >= 3 && k <= 5);
      $display("latency: cycle %0d req=%b expect c0_rvalid=%b", k, c0_req, exp_v);
      if (k < 3) begin
        checks++; if (c0_gnt_v[2] !== 1'b1) begin errors++;
          $display("FAIL latency_gnt k=%0d: got %b required 1", k, c0_gnt_v[2]); end
      end
      checks++; if (c0_rv_v[2] !== exp_v || c1_rv_v[2] !== 1'b0) begin errors++;
        $display("FAIL latency_rvalid k=%0d: c0=%b c1=%b required %b/0", k, c0_rv_v[2], c1_rv_v[2], exp_v); end
      if (exp_v) begin
        checks++; if (c0_rd_v[2] !== exp_mem(16'h0030 + 16'(k - 3))) begin errors++;
          $display("FAIL latency_rdata k=%0d: got %h required %h", k, c0_rd_v[2], exp_mem(16'h0030 + 16'(k - 3))); end
      end
      next_cycle();
    end
    c0_req = 0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    c0_req = 1; c0_we = 0; c0_addr = 16'h0050;
    #1;
    $display("reset_mid: c0 read 0050 then reset");
    checks++; if (c0_gnt_v[1] !== 1'b1) begin errors++;
      $display("FAIL midrst_gnt: got %b required 1", c0_gnt_v[1]); end
    next_cycle();
    c0_req = 0;
    rst_n = 0;
    #1;
    checks++; if (c0_rv_v[1] !== 1'b0 || c0_gnt_v[1] !== 1'b0) begin errors++;
      $display("FAIL midrst_hold: rvalid=%b gnt=%b required 0/0", c0_rv_v[1], c0_gnt_v[1]); end
    next_cycle();
    checks++; if (c0_rv_v[1] !== 1'b0 || c1_rv_v[1] !== 1'b0) begin errors++;
      $display("FAIL midrst_drop: c0=%b c1=%b required 0/0", c0_rv_v[1], c1_rv_v[1]); end
    rst_n = 1;
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      checks++; if (c0_rv_v[1] !== 1'b0 || c1_rv_v[1] !== 1'b0) begin errors++;
        $display("FAIL midrst_after k=%0d: c0=%b c1=%b required 0/0", k, c0_rv_v[1], c1_rv_v[1]); end
    end
    c0_req = 1; c1_req = 1; c0_addr = 16'h0051; c1_addr = 16'h0052;
    #1;
    $display("reset_mid: first tie after reset");
    checks++; if (c0_gnt_v[1] !== 1'b1 || c1_gnt_v[1] !== 1'b0) begin errors++;
      $display("FAIL midrst_tie: c0=%b c1=%b required 1/0", c0_gnt_v[1], c1_gnt_v[1]); end
    next_cycle();
    idle_inputs();
    next_cycle();
  endtask

`ifdef MEMBUS_ARB_LOCK_EN
  task automatic test_lock();
    do_reset();
    for (int k = 0; k < 6; k++) begin
      c1_req = 1; c1_we = 1; c1_addr = 16'h0040 + 16'(k); c1_wdata = 8'(k);
      c1_lock = (k < 5);
      c0_req = (k > 0); c0_we = 1; c0_addr = 16'h0060; c0_wdata = 8'hEE;
      #1;
      $display("lock: cycle %0d c1_lock=%b c0_req=%b", k, c1_lock, c0_req);
      if (k < 5) begin
        checks++; if (c1_gnt_v[0] !== 1'b1 || c0_gnt_v[0] !== 1'b0) begin errors++;
          $display("FAIL lock_hold k=%0d: c1=%b c0=%b required 1/0", k, c1_gnt_v[0], c0_gnt_v[0]); end
      end else begin
        checks++; if (c0_gnt_v[0] !== 1'b1 || c1_gnt_v[0] !== 1'b0) begin errors++;
          $display("FAIL lock_release: c0=%b c1=%b required 1/0", c0_gnt_v[0], c1_gnt_v[0]); end
      end
      next_cycle();
    end
    idle_inputs();
    next_cycle();
  endtask
`endif

  initial begin
    rst_n = 0;
    idle_inputs();
    test_reset();
    test_single();
    test_contention();
    test_write_read();
    test_latency();
    test_reset_mid();
`ifdef MEMBUS_ARB_LOCK_EN
    test_lock();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
